// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader: FSM encoding,
// word geometry and the per-word address step.
package instruction_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_IDX_W = $clog2(WORD_BYTES);
    localparam int unsigned COUNT_W    = 16;
    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned DATA_W     = 8 * WORD_BYTES;
    localparam logic [63:0] ADDR_STEP  = 64'd4;

endpackage

// File: rtl/instruction_loader_adder.sv
// 64-bit add/subtract unit; SUB=1 computes A-B via two's complement.
module Adder64b_mod (
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    input  logic        i_sub,
    output logic [63:0] o_sum
);

    logic [63:0] w_b_eff;

    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign o_sum   = i_a + w_b_eff + {63'd0, i_sub};

endmodule

// File: rtl/instruction_loader.sv
// Streams program bytes into 32-bit little-endian words and writes them to
// instruction memory at consecutive addresses, holding the core meanwhile.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'd0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [COUNT_W-1:0]   word_count,
    input  logic [7:0]           in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 mem_write,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_data,
    output logic                 busy,
    output logic                 done,
    output logic                 core_hold
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BYTE_IDX_W-1:0] r_byte_idx;
    logic [COUNT_W-1:0]    r_word_idx;
    logic [COUNT_W-1:0]    r_count;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_data;
    logic                  r_in_ready;
    logic                  r_mem_write;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_start_ok;
    logic                  w_accept;
    logic                  w_last;
    logic [COUNT_W-1:0]    w_eff_count;
    logic [ADDR_W-1:0]     w_addr_inc;

    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_accept    = r_in_ready && in_valid;
    assign w_last      = (r_word_idx == (r_count - COUNT_W'(1)));
    assign w_eff_count = (32'(word_count) > 32'(MAX_WORDS)) ? COUNT_W'(MAX_WORDS) : word_count;

    Adder64b_mod u_addr_add (
        .i_a   (r_addr),
        .i_b   (ADDR_STEP),
        .i_sub (1'b0),
        .o_sum (w_addr_inc)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_state_nxt = (word_count == '0) ? ST_DONE : ST_RECV;
            end
            ST_RECV: begin
                if (w_accept && (r_byte_idx == BYTE_IDX_W'(WORD_BYTES - 1))) w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                w_state_nxt = w_last ? ST_DONE : ST_RECV;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready  <= 1'b0;
            r_mem_write <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == ST_RECV);
            r_mem_write <= (w_state_nxt == ST_WRITE);
            r_busy      <= (w_state_nxt == ST_RECV) || (w_state_nxt == ST_WRITE);
            r_done      <= (w_state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_count    <= '0;
            r_addr     <= BASE_ADDR;
            r_data     <= '0;
        end else begin
            if (w_start_ok) begin
                r_byte_idx <= '0;
                r_word_idx <= '0;
                r_count    <= w_eff_count;
                r_addr     <= BASE_ADDR;
            end
            if (w_accept) begin
                r_data[{r_byte_idx, 3'b000} +: 8] <= in_byte;
                r_byte_idx                        <= r_byte_idx + BYTE_IDX_W'(1);
            end
            if ((r_state == ST_WRITE) && !w_last) begin
                r_word_idx <= r_word_idx + COUNT_W'(1);
                r_addr     <= w_addr_inc;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_addr;
    assign mem_data  = r_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign core_hold = r_busy;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: two instances (default base and
// base 0x100) driven in lockstep; writes are logged on the falling edge.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] word_count;
    logic [7:0]  in_byte;
    logic        in_valid;

    logic        rdy0, wr0, busy0, done0, hold0;
    logic [63:0] addr0;
    logic [31:0] data0;
    logic        rdy1, wr1, busy1, done1, hold1;
    logic [63:0] addr1;
    logic [31:0] data1;

    int total = 0;
    int bad   = 0;

    logic [63:0] q0_addr[$];
    logic [31:0] q0_data[$];
    logic [63:0] q1_addr[$];
    logic [31:0] q1_data[$];

    always #5 clk = ~clk;

    instruction_loader u_dut0 (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(rdy0),
        .mem_write(wr0), .mem_addr(addr0), .mem_data(data0),
        .busy(busy0), .done(done0), .core_hold(hold0)
    );

    instruction_loader #(.BASE_ADDR(64'h100), .MAX_WORDS(1024)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(rdy1),
        .mem_write(wr1), .mem_addr(addr1), .mem_data(data1),
        .busy(busy1), .done(done1), .core_hold(hold1)
    );

    always @(negedge clk) begin
        if (wr0) begin q0_addr.push_back(addr0); q0_data.push_back(data0); end
        if (wr1) begin q1_addr.push_back(addr1); q1_data.push_back(data1); end
    end

    task automatic clear_log();
        q0_addr.delete(); q0_data.delete(); q1_addr.delete(); q1_data.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00; word_count = 16'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_load(input logic [15:0] wc);
        @(negedge clk);
        start = 1'b1; word_count = wc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1; in_byte = b;
        while (!rdy1 && n < 20) begin @(negedge clk); n++; end
        if (!rdy1) begin
            total++; bad++;
            $display("FAIL send_byte_timeout: in_ready=%0b required=1", rdy1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            if (gap) @(negedge clk);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done1 && n < 50) begin @(negedge clk); n++; end
        total++;
        if (done1 !== 1'b1) begin
            bad++; $display("FAIL wait_done: done=%0b required=1", done1);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b/%0b required 0", busy0, busy1); end
        total++; if (done0 !== 1'b0 || hold0 !== 1'b0) begin bad++; $display("FAIL reset_done_hold: got %0b/%0b required 0", done0, hold0); end
        total++; if (rdy0 !== 1'b0 || wr0 !== 1'b0) begin bad++; $display("FAIL reset_ready_write: got %0b/%0b required 0", rdy0, wr0); end
        total++; if (addr0 !== 64'h0) begin bad++; $display("FAIL reset_addr0: got %h required 0", addr0); end
        total++; if (addr1 !== 64'h100) begin bad++; $display("FAIL reset_addr1: got %h required 100", addr1); end
        total++; if (data0 !== 32'h0) begin bad++; $display("FAIL reset_data: got %h required 0", data0); end
    endtask

    task automatic test_single_word();
        clear_log();
        start_load(16'd1);
        total++; if (rdy0 !== 1'b1 || busy0 !== 1'b1) begin bad++; $display("FAIL single_enter_recv: ready=%0b busy=%0b required 1/1", rdy0, busy0); end
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        total++; if (wr0 !== 1'b1) begin bad++; $display("FAIL single_write_latency: mem_write=%0b required 1", wr0); end
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL single_ready_in_write: in_ready=%0b required 0", rdy0); end
        @(negedge clk);
        total++; if (wr0 !== 1'b0 || done0 !== 1'b1) begin bad++; $display("FAIL single_done: mem_write=%0b done=%0b required 0/1", wr0, done0); end
        total++; if (q0_addr.size() != 1) begin bad++; $display("FAIL single_count: writes=%0d required 1", q0_addr.size()); end
        else begin
            total++; if (q0_addr[0] !== 64'h0) begin bad++; $display("FAIL single_addr: got %h required 0", q0_addr[0]); end
            total++; if (q0_data[0] !== 32'h00000013) begin bad++; $display("FAIL single_data: got %h required 00000013", q0_data[0]); end
        end
        total++; if (busy0 !== 1'b0 || hold0 !== 1'b0) begin bad++; $display("FAIL single_idle_busy: busy=%0b hold=%0b required 0", busy0, hold0); end
    endtask

    task automatic three_words(input bit gap, input string name);
        logic [31:0] words [3];
        logic [63:0] exp_addr;
        words[0] = 32'h11223344; words[1] = 32'hA5B6C7D8; words[2] = 32'h0BADF00D;
        clear_log();
        start_load(16'd3);
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(words[w][8*k +: 8]);
                total++;
                if (busy1 !== 1'b1 || hold1 !== 1'b1) begin
                    bad++; $display("FAIL %s_busy_w%0d_b%0d: busy=%0b hold=%0b required 1/1", name, w, k, busy1, hold1);
                end
                if (gap) @(negedge clk);
            end
        end
        wait_done();
        total++; if (q1_addr.size() != 3) begin bad++; $display("FAIL %s_count: writes=%0d required 3", name, q1_addr.size()); end
        else begin
            for (int w = 0; w < 3; w++) begin
                exp_addr = 64'h100 + 64'(4 * w);
                total++;
                if (q1_addr[w] !== exp_addr || q1_data[w] !== words[w]) begin
                    bad++; $display("FAIL %s_word%0d: addr=%h data=%h required addr=%h data=%h", name, w, q1_addr[w], q1_data[w], exp_addr, words[w]);
                end
            end
        end
    endtask

    task automatic test_zero_count();
        do_reset();
        clear_log();
        start_load(16'd0);
        total++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin bad++; $display("FAIL zero_done: done=%0b busy=%0b required 1/0", done1, busy1); end
        repeat (4) @(negedge clk);
        total++; if (q1_addr.size() != 0) begin bad++; $display("FAIL zero_writes: writes=%0d required 0", q1_addr.size()); end
    endtask

    task automatic test_max_words();
        logic [31:0] w;
        clear_log();
        start_load(16'd2000);
        for (int i = 0; i < 1024; i++) begin
            w = 32'(i) ^ 32'h5A000000;
            send_word(w, 1'b0);
        end
        wait_done();
        repeat (3) @(negedge clk);
        total++; if (q1_addr.size() != 1024) begin bad++; $display("FAIL max_count: writes=%0d required 1024", q1_addr.size()); end
        else begin
            total++; if (q1_addr[1023] !== 64'h10FC || q1_data[1023] !== 32'h5A0003FF) begin
                bad++; $display("FAIL max_last: addr=%h data=%h required 10fc/5a0003ff", q1_addr[1023], q1_data[1023]);
            end
        end
        total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL max_ready_after: in_ready=%0b required 0", rdy1); end
    endtask

    task automatic test_reset_midload();
        clear_log();
        start_load(16'd2);
        send_word(32'hCAFEBABE, 1'b0);
        @(negedge clk);
        send_byte(8'h01); send_byte(8'h02);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (wr1 !== 1'b0 || busy1 !== 1'b0 || rdy1 !== 1'b0 || done1 !== 1'b0) begin
            bad++; $display("FAIL midreset_state: write=%0b busy=%0b ready=%0b done=%0b required 0", wr1, busy1, rdy1, done1);
        end
        total++; if (addr1 !== 64'h100 || data1 !== 32'h0) begin bad++; $display("FAIL midreset_regs: addr=%h data=%h required 100/0", addr1, data1); end
        @(negedge clk);
        total++; if (q1_addr.size() != 1) begin bad++; $display("FAIL midreset_writes: writes=%0d required 1", q1_addr.size()); end
        clear_log();
        start_load(16'd1);
        send_word(32'h87654321, 1'b0);
        wait_done();
        total++; if (q1_addr.size() != 1 || q1_addr[0] !== 64'h100 || q1_data[0] !== 32'h87654321) begin
            bad++; $display("FAIL midreset_reload: writes=%0d first addr=%h data=%h required 1/100/87654321",
                            q1_addr.size(), (q1_addr.size() > 0) ? q1_addr[0] : 64'hX, (q1_data.size() > 0) ? q1_data[0] : 32'hX);
        end
    endtask

    task automatic test_start_while_busy();
        clear_log();
        start_load(16'd2);
        send_byte(8'hEF); send_byte(8'hBE);
        start = 1'b1; word_count = 16'd5;
        @(negedge clk);
        start = 1'b0;
        total++; if (busy1 !== 1'b1 || rdy1 !== 1'b1) begin bad++; $display("FAIL busy_start_state: busy=%0b ready=%0b required 1/1", busy1, rdy1); end
        send_byte(8'hAD); send_byte(8'hDE);
        send_word(32'h01020304, 1'b0);
        wait_done();
        repeat (3) @(negedge clk);
        total++; if (q1_addr.size() != 2) begin bad++; $display("FAIL busy_start_count: writes=%0d required 2", q1_addr.size()); end
        else begin
            total++; if (q1_addr[0] !== 64'h100 || q1_data[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL busy_start_w0: addr=%h data=%h required 100/deadbeef", q1_addr[0], q1_data[0]); end
            total++; if (q1_addr[1] !== 64'h104 || q1_data[1] !== 32'h01020304) begin bad++; $display("FAIL busy_start_w1: addr=%h data=%h required 104/01020304", q1_addr[1], q1_data[1]); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; word_count = 16'd0; in_byte = 8'h00; in_valid = 1'b0;
        test_reset();
        test_single_word();
        three_words(1'b0, "three_words");
        three_words(1'b1, "gapped");
        test_zero_count();
        test_max_words();
        test_reset_midload();
        test_start_while_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
